mem_c_deskew: RTL



---
 rtl/mem_c_pkg.sv | 18 +
 rtl/mem_c_col.sv | 46 ++++
 rtl/mem_c_deskew.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_c_pkg.sv
// Shared types and constants for the systolic C-side deskew buffer.
package mem_c_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int BITS_C_DEF = 16;
  localparam int DIM_DEF    = 8;

  // Number of enabled capture cycles needed to drain a skewed DIM x DIM result.
  function automatic int cap_len(input int dim);
    return 2 * dim - 1;
  endfunction

endpackage

// File: rtl/mem_c_col.sv
// One result column: DIM signed registers written along the skew diagonal,
// plus a combinational row-select read mux.
module mem_c_col
  import mem_c_pkg::*;
#(
  parameter int BITS_C = BITS_C_DEF,
  parameter int DIM    = DIM_DEF,
  parameter int COL    = 0,
  localparam int CW    = $clog2(2 * DIM),
  localparam int RW    = $clog2(DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic              clr_i,
  input  logic [CW-1:0]     cnt_i,
  input  logic [BITS_C-1:0] din_i,
  input  logic [RW-1:0]     rd_row_i,
  output logic [BITS_C-1:0] rd_data_o
);

  logic [BITS_C-1:0] mem_q [DIM];
  logic [CW:0]       row_full_s;
  logic              in_win_s;
  logic [RW-1:0]     row_s;

  // Row index for this column is cnt-COL; a borrow or a value >= DIM falls outside the window.
  always_comb begin
    row_full_s = {1'b0, cnt_i} - (CW + 1)'(COL);
    in_win_s   = (row_full_s[CW:RW] == '0);
    row_s      = row_full_s[RW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIM; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DIM; i++) mem_q[i] <= '0;
    end else if (wr_en_i && in_win_s) begin
      mem_q[row_s] <= din_i;
    end
  end

  assign rd_data_o = mem_q[rd_row_i];

endmodule

// File: rtl/mem_c_deskew.sv
// Deskews the systolic array's C output into a DIM x DIM register array and
// serves one row per read. Optional MEM_C_DESKEW_CLEAR_ON_START_EN: start also zeros storage.
module mem_c_deskew
  import mem_c_pkg::*;
#(
  parameter int BITS_C = BITS_C_DEF,
  parameter int DIM    = DIM_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         en,
  input  logic [DIM-1:0][BITS_C-1:0]   Cin,
  input  logic [$clog2(DIM)-1:0]       Crow,
  output logic [DIM-1:0][BITS_C-1:0]   Cout,
  output logic                         busy,
  output logic                         done
);

  localparam int CW = $clog2(2 * DIM);
  localparam logic [CW-1:0] CNT_LAST = CW'(cap_len(DIM) - 1);

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       busy_q, done_q;
  logic [DIM-1:0][BITS_C-1:0] cout_q;
  logic [DIM-1:0][BITS_C-1:0] rd_row_s;
  logic                       wr_en_s;
  logic                       clr_s;

  // start always (re)enters CAPTURE from cnt 0 and masks any en in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      CAPTURE: begin
        if (start) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else if (en) begin
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            state_d = CAPTURE;
            cnt_d   = cnt_q + CW'(1);
          end
        end else begin
          state_d = CAPTURE;
          cnt_d   = cnt_q;
        end
      end
      DONE: begin
        if (start) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign wr_en_s = (state_q == CAPTURE) && en && !start;

`ifdef MEM_C_DESKEW_CLEAR_ON_START_EN
  assign clr_s = start;
`else
  assign clr_s = 1'b0;
`endif

  for (genvar j = 0; j < DIM; j++) begin : g_col
    mem_c_col #(
      .BITS_C (BITS_C),
      .DIM    (DIM),
      .COL    (j)
    ) u_col (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en_s),
      .clr_i     (clr_s),
      .cnt_i     (cnt_q),
      .din_i     (Cin[j]),
      .rd_row_i  (Crow),
      .rd_data_o (rd_row_s[j])
    );
  end

  // Cout samples storage before this edge's write/clear lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == CAPTURE);
      done_q  <= (state_d == DONE);
      cout_q  <= rd_row_s;
    end
  end

  assign Cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
